// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared types and constants for the USR shift sequencer
package usr_pkg;

  localparam int USR_WIDTH = 8;
  localparam int USR_CNT_W = 4;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } usr_state_e;

  typedef struct packed {
    logic                 load;
    logic                 dir;
    logic [USR_CNT_W-1:0] count;
    logic [USR_WIDTH-1:0] data;
  } usr_cmd_t;

endpackage

// File: rtl/usr_cmd_queue.sv
// rtl/usr_cmd_queue.sv - 2-entry command FIFO in front of the shift sequencer
module usr_cmd_queue #(
  parameter int DW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tvalid,
  output logic          s_tready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    cnt;
  logic          do_push;
  logic          do_pop;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  always_comb begin
    do_pop   = m_tready && (cnt != 2'd0);
    do_push  = s_tvalid && ((cnt != 2'd2) || do_pop);
    s_tready = (cnt != 2'd2);
    m_tvalid = (cnt != 2'd0);
    m_tdata  = mem[rd_ptr];
  end

  // Storage is data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= s_tdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/usr_shift_sequencer.sv
// rtl/usr_shift_sequencer.sv - load/shift command sequencer for the USR (option: USR_SEQ_QUEUE_EN)
module usr_shift_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH,
  parameter int CNT_W = USR_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             SL,
  output logic             SR,
  output logic             LD,
  output logic [WIDTH-1:0] PI,
  output logic             busy,
  output logic             done
);

  typedef struct packed {
    logic             load;
    logic             dir;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  cmd_t       in_cmd;
  cmd_t       head_cmd;
  logic       head_valid;
  logic       take;
  cmd_t       cmd_q, cmd_d;
  usr_state_e state_q, state_d;
  logic [CNT_W-1:0] count_c;
  logic sl_d, sr_d, ld_d, busy_d, done_d;

  assign in_cmd = '{load: cmd_load, dir: cmd_dir, count: cmd_count, data: cmd_data};

`ifdef USR_SEQ_QUEUE_EN
  logic q_full_n;
  logic rdy_en;

  // Holds cmd_ready low through reset and for the first cycle after it.
  always_ff @(posedge CLK) begin
    if (RST) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  assign cmd_ready = rdy_en && q_full_n;

  usr_cmd_queue #(.DW(CMD_W)) u_queue (
    .clk      (CLK),
    .rst      (RST),
    .s_tdata  (in_cmd),
    .s_tvalid (cmd_valid && cmd_ready),
    .s_tready (q_full_n),
    .m_tdata  (head_cmd),
    .m_tvalid (head_valid),
    .m_tready (take)
  );
`else
  logic ready_q;

  assign cmd_ready  = ready_q;
  assign head_valid = cmd_valid && cmd_ready;
  assign head_cmd   = in_cmd;
`endif

  // Next state, next command register and next registered outputs.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    count_c = (head_cmd.count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : head_cmd.count;
`ifdef USR_SEQ_QUEUE_EN
    take    = head_valid && ((state_q == IDLE) || (state_q == DONE));
`else
    take    = head_valid && (state_q == IDLE);
`endif
    case (state_q)
      IDLE:    state_d = IDLE;
      LOAD:    state_d = (cmd_q.count != '0) ? SHIFT : DONE;
      SHIFT: begin
        cmd_d.count = cmd_q.count - 1'b1;
        if (cmd_q.count <= CNT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (take) begin
      cmd_d       = head_cmd;
      cmd_d.count = count_c;
      state_d     = LOAD;
    end
    sl_d   = (state_d == SHIFT) && (cmd_d.dir == DIR_LEFT);
    sr_d   = (state_d == SHIFT) && (cmd_d.dir == DIR_RIGHT);
    ld_d   = (state_d == LOAD) && cmd_d.load;
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, command and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      SL      <= 1'b0;
      SR      <= 1'b0;
      LD      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      SL      <= sl_d;
      SR      <= sr_d;
      LD      <= ld_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

`ifndef USR_SEQ_QUEUE_EN
  // Ready is registered from the next state so it is high exactly in IDLE.
  always_ff @(posedge CLK) begin
    if (RST) ready_q <= 1'b0;
    else     ready_q <= (state_d == IDLE);
  end
`endif

  assign PI = cmd_q.data;

endmodule
